// File: rtl/bf_machine_v2.sv
// rtl/bf_machine_v2.sv - brainfuck core with loadable program, bracket pre-scan and tape clear
module bf_machine_v2 #(
   parameter int TAPE_LENGTH    = 256,
   parameter int WORD_SIZE      = 8,
   parameter int PROGRAM_LENGTH = 64,
   parameter int MAX_DEPTH      = 15
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  prog_wr_en,
   input  logic [$clog2(PROGRAM_LENGTH)-1:0]     prog_wr_addr,
   input  logic [2:0]                            prog_wr_data,
   input  logic [$clog2(PROGRAM_LENGTH+1)-1:0]   prog_len,
   input  logic                                  start,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  error,
   output logic [1:0]                            err_code,
   input  logic [WORD_SIZE-1:0]                  in_data,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   output logic [WORD_SIZE-1:0]                  out_data,
   output logic                                  out_valid,
   input  logic                                  out_ready
);

   localparam int AW = $clog2(PROGRAM_LENGTH);
   localparam int LW = $clog2(PROGRAM_LENGTH + 1);
   localparam int TW = $clog2(TAPE_LENGTH);
   localparam int DW = $clog2(MAX_DEPTH + 1);

   localparam logic [2:0] OP_INC  = 3'd0;
   localparam logic [2:0] OP_DEC  = 3'd1;
   localparam logic [2:0] OP_RGT  = 3'd2;
   localparam logic [2:0] OP_LFT  = 3'd3;
   localparam logic [2:0] OP_OUT  = 3'd4;
   localparam logic [2:0] OP_IN   = 3'd5;
   localparam logic [2:0] OP_OPEN = 3'd6;
   localparam logic [2:0] OP_CLS  = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE, S_SCAN, S_CLEAR, S_RUN, S_DONE, S_ERROR
   } state_t;

   state_t                r_state;
   state_t                w_next_state;

   logic [2:0]            r_prog  [PROGRAM_LENGTH];
   logic [WORD_SIZE-1:0]  r_tape  [TAPE_LENGTH];
   logic [AW-1:0]         r_jmp   [PROGRAM_LENGTH];
   logic [AW-1:0]         r_stack [MAX_DEPTH];

   logic [LW-1:0]         r_len;
   logic [LW-1:0]         r_pc;
   logic [LW-1:0]         r_scan;
   logic [TW-1:0]         r_clr;
   logic [TW-1:0]         r_tp;
   logic [DW-1:0]         r_sp;
   logic [1:0]            r_err_code;
   logic                  r_out_valid;
   logic [WORD_SIZE-1:0]  r_out_data;

   logic                  w_busy;
   logic                  w_start_ok;
   logic                  w_len_bad;
   logic [AW-1:0]         w_scan_idx;
   logic [AW-1:0]         w_pc_idx;
   logic [2:0]            w_scan_op;
   logic [2:0]            w_pc_op;
   logic                  w_scan_end;
   logic                  w_pc_end;
   logic [WORD_SIZE-1:0]  w_cell;
   logic [AW-1:0]         w_top;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_err_set;
   logic [1:0]            w_err_val;
   logic                  w_advance;
   logic                  w_out_load;
   logic                  w_in_take;
   logic [LW-1:0]         w_pc_nxt;

   assign w_busy     = (r_state == S_SCAN) || (r_state == S_CLEAR) || (r_state == S_RUN);
   assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
   assign w_len_bad  = (prog_len == '0) || (prog_len > LW'(PROGRAM_LENGTH));
   assign w_scan_idx = r_scan[AW-1:0];
   assign w_pc_idx   = r_pc[AW-1:0];
   assign w_scan_op  = r_prog[w_scan_idx];
   assign w_pc_op    = r_prog[w_pc_idx];
   assign w_scan_end = (r_scan == r_len);
   assign w_pc_end   = (r_pc == r_len);
   assign w_cell     = r_tape[r_tp];
   assign w_top      = r_stack[r_sp - DW'(1)];

   assign busy      = w_busy;
   assign done      = (r_state == S_DONE);
   assign error     = (r_state == S_ERROR);
   assign err_code  = r_err_code;
   assign in_ready  = (r_state == S_RUN) && !w_pc_end && (w_pc_op == OP_IN);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // Next state, scan stack control, run-time stall/advance decisions
   always_comb begin
      w_next_state = r_state;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      w_err_set    = 1'b0;
      w_err_val    = 2'd0;
      w_advance    = 1'b0;
      w_out_load   = 1'b0;
      w_in_take    = 1'b0;
      w_pc_nxt     = r_pc + LW'(1);
      if (((w_pc_op == OP_OPEN) && (w_cell == '0)) || ((w_pc_op == OP_CLS) && (w_cell != '0)))
         w_pc_nxt = LW'(r_jmp[w_pc_idx]) + LW'(1);
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               w_err_set = 1'b1;
               if (w_len_bad) begin
                  w_next_state = S_ERROR;
                  w_err_val    = 2'd3;
               end else begin
                  w_next_state = S_SCAN;
               end
            end
         end
         S_SCAN: begin
            if (w_scan_end) begin
               if (r_sp != '0) begin
                  w_next_state = S_ERROR;
                  w_err_set    = 1'b1;
                  w_err_val    = 2'd1;
               end else begin
                  w_next_state = S_CLEAR;
               end
            end else if (w_scan_op == OP_OPEN) begin
               if (r_sp == DW'(MAX_DEPTH)) begin
                  w_next_state = S_ERROR;
                  w_err_set    = 1'b1;
                  w_err_val    = 2'd2;
               end else begin
                  w_push = 1'b1;
               end
            end else if (w_scan_op == OP_CLS) begin
               if (r_sp == '0) begin
                  w_next_state = S_ERROR;
                  w_err_set    = 1'b1;
                  w_err_val    = 2'd1;
               end else begin
                  w_pop = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            if (r_clr == TW'(TAPE_LENGTH - 1)) w_next_state = S_RUN;
         end
         S_RUN: begin
            if (w_pc_end) begin
               w_next_state = S_DONE;
            end else if (w_pc_op == OP_OUT) begin
               if (!(r_out_valid && !out_ready)) begin
                  w_out_load = 1'b1;
                  w_advance  = 1'b1;
               end
            end else if (w_pc_op == OP_IN) begin
               if (in_valid) begin
                  w_in_take = 1'b1;
                  w_advance = 1'b1;
               end
            end else begin
               w_advance = 1'b1;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Program memory write port, locked out while the core is busy
   always_ff @(posedge clk) begin
      if (prog_wr_en && !w_busy) r_prog[prog_wr_addr] <= prog_wr_data;
   end

   // Tape: cleared sequentially in CLEAR, modified by + - , in RUN
   always_ff @(posedge clk) begin
      if (r_state == S_CLEAR) begin
         r_tape[r_clr] <= '0;
      end else if (w_advance) begin
         if (w_pc_op == OP_INC)      r_tape[r_tp] <= w_cell + WORD_SIZE'(1);
         else if (w_pc_op == OP_DEC) r_tape[r_tp] <= w_cell - WORD_SIZE'(1);
         else if (w_in_take)         r_tape[r_tp] <= in_data;
      end
   end

   // Pointers, scan stack, jump table and error code
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len      <= '0;
         r_pc       <= '0;
         r_scan     <= '0;
         r_clr      <= '0;
         r_tp       <= '0;
         r_sp       <= '0;
         r_err_code <= 2'd0;
         for (int i = 0; i < MAX_DEPTH; i++)      r_stack[i] <= '0;
         for (int i = 0; i < PROGRAM_LENGTH; i++) r_jmp[i]   <= '0;
      end else begin
         if (w_err_set) r_err_code <= w_err_val;
         if (w_start_ok) begin
            r_len  <= prog_len;
            r_pc   <= '0;
            r_scan <= '0;
            r_clr  <= '0;
            r_tp   <= '0;
            r_sp   <= '0;
         end
         if ((r_state == S_SCAN) && !w_scan_end) r_scan <= r_scan + LW'(1);
         if (w_push) begin
            r_stack[r_sp] <= w_scan_idx;
            r_sp          <= r_sp + DW'(1);
         end
         if (w_pop) begin
            r_jmp[w_scan_idx] <= w_top;
            r_jmp[w_top]      <= w_scan_idx;
            r_sp              <= r_sp - DW'(1);
         end
         if (r_state == S_CLEAR) r_clr <= r_clr + TW'(1);
         if (w_advance) begin
            r_pc <= w_pc_nxt;
            if (w_pc_op == OP_RGT)      r_tp <= r_tp + TW'(1);
            else if (w_pc_op == OP_LFT) r_tp <= r_tp - TW'(1);
         end
      end
   end

   // Output byte register with valid/ready handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_out_load) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_cell;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bf_machine_v2.sv
// tb/tb_bf_machine_v2.sv - directed self-checking bench for bf_machine_v2
module tb_bf_machine_v2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       prog_wr_en = 1'b0;
   logic [5:0] prog_wr_addr = '0;
   logic [2:0] prog_wr_data = '0;
   logic [6:0] prog_len = '0;
   logic       start = 1'b0;
   logic       busy, done, error;
   logic [1:0] err_code;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] q[$];
   int         cnt;
   int         ok;
   logic       seen_out;

   bf_machine_v2 dut (
      .clk(clk), .rst_n(rst_n),
      .prog_wr_en(prog_wr_en), .prog_wr_addr(prog_wr_addr), .prog_wr_data(prog_wr_data),
      .prog_len(prog_len), .start(start),
      .busy(busy), .done(done), .error(error), .err_code(err_code),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] opc(input byte c);
      case (c)
         "+": return 3'd0;
         "-": return 3'd1;
         ">": return 3'd2;
         "<": return 3'd3;
         ".": return 3'd4;
         ",": return 3'd5;
         "[": return 3'd6;
         default: return 3'd7;
      endcase
   endfunction

   task automatic load(input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         prog_wr_en   = 1'b1;
         prog_wr_addr = 6'(i);
         prog_wr_data = opc(s[i]);
      end
      @(negedge clk);
      prog_wr_en = 1'b0;
   endtask

   task automatic go(input int len);
      @(negedge clk);
      prog_len = 7'(len);
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   // Collect output bytes until the run ends with nothing pending
   task automatic finish_run(input string tag, input int budget);
      q.delete();
      ok = 0;
      for (int c = 0; c < budget; c++) begin
         if (out_valid && out_ready) q.push_back(out_data);
         if ((done || error) && !out_valid) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      chk({tag, "_completes"}, ok, 1);
   endtask

   function automatic int qb(input int i);
      return (q.size() > i) ? int'(q[i]) : -1;
   endfunction

   task automatic err_case(input string tag, input int len, input int code);
      go(len);
      finish_run(tag, 400);
      chk({tag, "_error"}, error, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_code"}, err_code, code);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_outv", out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // "+++." -> single byte 3
      load("+++.");
      go(4);
      finish_run("t1", 600);
      chk("t1_count", q.size(), 1);
      chk("t1_b0", qb(0), 3);
      chk("t1_done", done, 1);
      chk("t1_error", error, 0);
      chk("t1_code", err_code, 0);

      // start together with a write in DONE: program becomes "-++." -> 1
      @(negedge clk);
      prog_len     = 7'd4;
      start        = 1'b1;
      prog_wr_en   = 1'b1;
      prog_wr_addr = 6'd0;
      prog_wr_data = 3'd1;
      @(negedge clk);
      start      = 1'b0;
      prog_wr_en = 1'b0;
      finish_run("wr_start", 600);
      chk("wr_start_b0", qb(0), 1);

      // ",[.-]" with backpressure on the first byte
      load(",[.-]");
      in_data   = 8'd3;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      go(5);
      ok = 0;
      for (int c = 0; c < 600; c++) begin
         if (out_valid) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      chk("t2_first_valid", ok, 1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t2_hold_valid", out_valid, 1);
         chk("t2_hold_data", out_data, 3);
         chk("t2_hold_inrdy", in_ready, 0);
      end
      out_ready = 1'b1;
      finish_run("t2", 200);
      chk("t2_count", q.size(), 3);
      chk("t2_b0", qb(0), 3);
      chk("t2_b1", qb(1), 2);
      chk("t2_b2", qb(2), 1);
      chk("t2_done", done, 1);

      // Error cases
      load("[[]");
      err_case("unbal_open", 3, 1);
      load("]");
      err_case("unbal_close", 1, 1);
      load("[[[[[[[[[[[[[[[[");
      err_case("depth", 16, 2);
      err_case("len_zero", 0, 3);
      err_case("len_over", 65, 3);

      // "<-." -> tp wraps to 255, cell 255
      load("<-.");
      go(3);
      finish_run("t4", 600);
      chk("t4_count", q.size(), 1);
      chk("t4_b0", qb(0), 255);
      chk("t4_done", done, 1);

      // "[+.]" skipped loop; exact done latency, ignored start/write while busy
      load("[+.]");
      go(4);
      cnt = 0;
      seen_out = 1'b0;
      while (!done && cnt < 1000) begin
         if (cnt == 2) begin
            start        = 1'b1;
            prog_wr_en   = 1'b1;
            prog_wr_addr = 6'd0;
            prog_wr_data = 3'd7;
         end else begin
            start      = 1'b0;
            prog_wr_en = 1'b0;
         end
         @(negedge clk);
         cnt++;
         if (out_valid) seen_out = 1'b1;
      end
      start      = 1'b0;
      prog_wr_en = 1'b0;
      chk("t5_latency", cnt, 4 + 256 + 3);
      chk("t5_no_output", seen_out, 0);

      // Reset mid-run of ",[.-]", then restart without reloading
      load(",[.-]");
      out_ready = 1'b0;
      go(5);
      ok = 0;
      for (int c = 0; c < 600; c++) begin
         if (out_valid) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      chk("t6_reached_run", ok, 1);
      chk("t6_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_done", done, 0);
      chk("t6_rst_error", error, 0);
      chk("t6_rst_code", err_code, 0);
      chk("t6_rst_outv", out_valid, 0);
      chk("t6_rst_outd", out_data, 0);
      chk("t6_rst_inrdy", in_ready, 0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      go(5);
      finish_run("t6", 600);
      chk("t6_count", q.size(), 3);
      chk("t6_b0", qb(0), 3);
      chk("t6_b1", qb(1), 2);
      chk("t6_b2", qb(2), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
